// File: rtl/dcache_resp.sv
// dcache_resp: CPU-side responder for a direct-mapped, one-word-per-line,
// write-through, no-write-allocate data cache.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   Valid_cpu2cache_i            CPU request valid (held until Ready)
//   MemRW_i                      1 = store, 0 = load
//   addr_i, wdata_i              byte address (bits [1:0] ignored), store data
//   flush_i                      invalidate all lines (honoured in IDLE only)
//   rdata_o                      load data, valid with Ready_cache2cpu_o
//   Ready_cache2cpu_o            one-cycle completion pulse
//   stall_o                      pipeline hold = valid & ~ready
//   mem_valid_o/mem_we_o         backing-memory request / write enable
//   mem_addr_o/mem_wdata_o       word-aligned address / write data
//   mem_ready_i/mem_rdata_i      backing-memory accept / read data
module dcache_resp #(
  parameter int unsigned LINES = 16,
  localparam int unsigned IDX_W = $clog2(LINES),
  localparam int unsigned TAG_W = 30 - IDX_W
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        Valid_cpu2cache_i,
  input  logic        MemRW_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        flush_i,
  output logic [31:0] rdata_o,
  output logic        Ready_cache2cpu_o,
  output logic        stall_o,
  output logic        mem_valid_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_RD,
    S_WR_THRU,
    S_RESP
  } state_e;

  state_e state_q, state_d;

  logic [29:0]      req_word_q;
  logic [31:0]      req_wdata_q;
  logic             req_we_q;
  logic             hit_q;
  logic [31:0]      rdata_q;
  logic [LINES-1:0] valid_q;

  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             lookup_hit;
  logic             unused_addr;

  assign req_idx     = req_word_q[IDX_W-1:0];
  assign req_tag     = req_word_q[29:IDX_W];
  assign lookup_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign unused_addr = ^addr_i[1:0];

  always_comb begin
    state_d     = state_q;
    mem_valid_o = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (state_q)
      S_IDLE: begin
        if (!flush_i && Valid_cpu2cache_i) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (req_we_q)        state_d = S_WR_THRU;
        else if (lookup_hit) state_d = S_RESP;
        else                 state_d = S_MISS_RD;
      end
      S_MISS_RD: begin
        mem_valid_o = 1'b1;
        mem_addr_o  = {req_word_q, 2'b00};
        if (mem_ready_i) state_d = S_RESP;
      end
      S_WR_THRU: begin
        mem_valid_o = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {req_word_q, 2'b00};
        mem_wdata_o = req_wdata_q;
        if (mem_ready_i) state_d = S_RESP;
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rdata_o           = rdata_q;
  assign Ready_cache2cpu_o = (state_q == S_RESP);
  assign stall_o           = Valid_cpu2cache_i & ~Ready_cache2cpu_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      req_word_q  <= '0;
      req_wdata_q <= '0;
      req_we_q    <= 1'b0;
      hit_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: begin
          // Flush wins over a same-cycle request; the request is taken next cycle.
          if (flush_i) begin
            valid_q <= '0;
          end else if (Valid_cpu2cache_i) begin
            req_word_q  <= addr_i[31:2];
            req_wdata_q <= wdata_i;
            req_we_q    <= MemRW_i;
          end
        end
        S_LOOKUP: begin
          // Remember the hit so a store can update the line after the write beat.
          hit_q <= lookup_hit;
          if (!req_we_q && lookup_hit) rdata_q <= data_q[req_idx];
        end
        S_MISS_RD: begin
          if (mem_ready_i) begin
            valid_q[req_idx] <= 1'b1;
            rdata_q          <= mem_rdata_i;
          end
        end
        S_WR_THRU: begin
          if (mem_ready_i) rdata_q <= '0;
        end
        default: ;
      endcase
    end
  end

  // Tag/data storage carries no reset; the valid bits gate every use.
  always_ff @(posedge clk_i) begin
    if (state_q == S_MISS_RD && mem_ready_i) begin
      tag_q[req_idx]  <= req_tag;
      data_q[req_idx] <= mem_rdata_i;
    end else if (state_q == S_WR_THRU && mem_ready_i && hit_q) begin
      data_q[req_idx] <= req_wdata_q;
    end
  end

endmodule

// File: tb/tb_dcache_resp.sv
module tb_dcache_resp;

  localparam int unsigned LINES = 16;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        Valid_cpu2cache_i;
  logic        MemRW_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        flush_i;
  logic [31:0] rdata_o;
  logic        Ready_cache2cpu_o;
  logic        stall_o;
  logic        mem_valid_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;

  dcache_resp #(.LINES(LINES)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .Valid_cpu2cache_i (Valid_cpu2cache_i),
    .MemRW_i           (MemRW_i),
    .addr_i            (addr_i),
    .wdata_i           (wdata_i),
    .flush_i           (flush_i),
    .rdata_o           (rdata_o),
    .Ready_cache2cpu_o (Ready_cache2cpu_o),
    .stall_o           (stall_o),
    .mem_valid_o       (mem_valid_o),
    .mem_we_o          (mem_we_o),
    .mem_addr_o        (mem_addr_o),
    .mem_wdata_o       (mem_wdata_o),
    .mem_ready_i       (mem_ready_i),
    .mem_rdata_i       (mem_rdata_i)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit abort = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    int          start;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mtx_t;

  resp_t sb[$];
  mtx_t  mq[$];
  int    wq[$];

  // Reference model: which memory words are currently held, and memory contents.
  bit          ref_valid [LINES];
  int unsigned ref_tag   [LINES];
  logic [31:0] ref_mem   [int unsigned];
  logic [31:0] bmem      [int unsigned];

  function automatic logic [31:0] init_val(int unsigned w);
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] ref_rd(int unsigned w);
    return ref_mem.exists(w) ? ref_mem[w] : init_val(w);
  endfunction

  function automatic logic [31:0] bmem_rd(int unsigned w);
    return bmem.exists(w) ? bmem[w] : init_val(w);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Issue one CPU request at a negedge; expectations go to the queues.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input int n, input bit fl);
    int unsigned w, idx, tag;
    bit hit, done;
    resp_t r;
    w   = addr / 4;
    idx = w % LINES;
    tag = w / LINES;
    if (fl) for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
    hit = ref_valid[idx] && (ref_tag[idx] == tag);
    r.start = fl ? cyc + 1 : cyc;
    if (!we) begin
      r.rdata = ref_rd(w);
      r.lat   = hit ? 2 : 3 + n;
      if (!hit) begin
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = tag;
        mq.push_back('{1'b0, w * 4, 32'h0});
        wq.push_back(n);
      end
    end else begin
      ref_mem[w] = wd;
      r.rdata = '0;
      r.lat   = 3 + n;
      mq.push_back('{1'b1, w * 4, wd});
      wq.push_back(n);
    end
    sb.push_back(r);
    Valid_cpu2cache_i = 1'b1;
    MemRW_i           = we;
    addr_i            = addr;
    wdata_i           = wd;
    flush_i           = fl;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      flush_i = 1'b0;
      if (k == 0) chk("stall_busy", {31'b0, stall_o}, 32'd1);
      if (Ready_cache2cpu_o) done = 1'b1;
    end
    if (!done) chk("ready_timeout", 32'd0, 32'd1);
    Valid_cpu2cache_i = 1'b0;
    @(negedge clk);
  endtask

  // Response monitor.
  initial begin
    resp_t r;
    forever begin
      @(posedge clk);
      #1;
      if (Ready_cache2cpu_o && !rst_i) begin
        chk("stall_at_ready", {31'b0, stall_o}, 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_ready", 32'd1, 32'd0);
        end else begin
          r = sb.pop_front();
          chk("rdata", rdata_o, r.rdata);
          chk("latency", cyc - r.start, r.lat);
        end
      end
    end
  end

  // Backing-memory responder and memory-side checker.
  initial begin
    mtx_t cur;
    int w;
    bit in_txn;
    mem_ready_i = 1'b0;
    mem_rdata_i = '0;
    in_txn = 1'b0;
    w = 0;
    forever begin
      @(negedge clk);
      if (abort || rst_i) begin
        mem_ready_i = 1'b0;
        in_txn = 1'b0;
      end else if (mem_ready_i) begin
        mem_ready_i = 1'b0;
        chk("mem_valid_drop", {31'b0, mem_valid_o}, 32'd0);
      end else if (mem_valid_o) begin
        if (!in_txn) begin
          if (mq.size() == 0) begin
            chk("unexpected_mem_req", mem_addr_o, 32'hFFFF_FFFF);
            cur = '{mem_we_o, mem_addr_o, mem_wdata_o};
            w = 0;
          end else begin
            cur = mq.pop_front();
            w = (wq.size() != 0) ? wq.pop_front() : 0;
          end
          in_txn = 1'b1;
        end
        chk("mem_we", {31'b0, mem_we_o}, {31'b0, cur.we});
        chk("mem_addr", mem_addr_o, cur.addr);
        if (cur.we) chk("mem_wdata", mem_wdata_o, cur.wdata);
        if (w == 0) begin
          if (cur.we) bmem[cur.addr / 4] = cur.wdata;
          else        mem_rdata_i = bmem_rd(cur.addr / 4);
          mem_ready_i = 1'b1;
          in_txn = 1'b0;
        end else begin
          w--;
        end
      end
    end
  end

  initial begin
    bit ok;
    for (int i = 0; i < LINES; i++) begin
      ref_valid[i] = 1'b0;
      ref_tag[i]   = 0;
    end
    bmem[32'h40 / 4]    = 32'hDEAD_BEEF;
    ref_mem[32'h40 / 4] = 32'hDEAD_BEEF;
    Valid_cpu2cache_i = 1'b0;
    MemRW_i = 1'b0;
    addr_i  = '0;
    wdata_i = '0;
    flush_i = 1'b0;
    rst_i   = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_ready", {31'b0, Ready_cache2cpu_o}, 32'd0);
    chk("rst_mem_valid", {31'b0, mem_valid_o}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mem_wdata", mem_wdata_o, 32'd0);
    chk("rst_stall", {31'b0, stall_o}, 32'd0);
    rst_i = 1'b0;
    @(negedge clk);

    // Directed sequence.
    issue(1'b0, 32'h40, 32'h0, 2, 1'b0);          // miss, 2 wait cycles
    issue(1'b0, 32'h40, 32'h0, 0, 1'b0);          // hit
    issue(1'b1, 32'h40, 32'h1234_5678, 0, 1'b0);  // store hit
    issue(1'b0, 32'h40, 32'h0, 0, 1'b0);          // hit, updated data
    issue(1'b1, 32'h80, 32'hCAFE_F00D, 1, 1'b0);  // store miss, no allocate
    issue(1'b0, 32'h80, 32'h0, 1, 1'b0);          // miss, replaces 0x40
    issue(1'b0, 32'h40, 32'h0, 0, 1'b0);          // miss again (index wrap)
    issue(1'b0, 32'h43, 32'h0, 0, 1'b0);          // hit, low bits ignored
    issue(1'b0, 32'h40, 32'h0, 0, 1'b1);          // flush + request together

    // Randomized traffic over a small address pool to force conflicts.
    for (int i = 0; i < 250; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 63) << 2) | ($urandom & 32'h3);
      issue(1'($urandom_range(0, 2) == 0), a, $urandom, $urandom_range(0, 3),
            $urandom_range(0, 9) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset while a miss is waiting on memory.
    abort = 1'b1;
    Valid_cpu2cache_i = 1'b1;
    MemRW_i = 1'b0;
    addr_i  = 32'h100;
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      if (mem_valid_o) ok = 1'b1;
    end
    chk("miss_rd_reached", {31'b0, ok}, 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("abort_mem_valid", {31'b0, mem_valid_o}, 32'd0);
    chk("abort_ready", {31'b0, Ready_cache2cpu_o}, 32'd0);
    chk("abort_mem_addr", mem_addr_o, 32'd0);
    Valid_cpu2cache_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
    @(negedge clk);
    issue(1'b0, 32'h40, 32'h0, 1, 1'b0);          // misses after reset

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    chk("mq_empty", mq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dcache_resp.md
Name: dcache_resp

Overview:
- Cache-side responder for the CPU data-access interface.
- It accepts the request driven from the MEM pipeline register (Valid_cpu2cache, MemRW, ALU address, rs2 store data) and answers from a direct-mapped, one-word-per-line, write-through, no-write-allocate data cache.
- While a request is outstanding it stalls the pipeline. It fetches misses and forwards all writes to backing memory over a valid/ready handshake.

Parameters:
- LINES, 16, number of cache lines; power of two, at least 2. IDX_W = log2(LINES).
- TAG_W, 30-IDX_W, tag width (derived; not overridden).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- Valid_cpu2cache_i  in  1  CPU request valid; held with its fields until Ready_cache2cpu_o.
- MemRW_i  in  1  1=store, 0=load.
- addr_i  in  32  byte address; bits [1:0] ignored (word access only).
- wdata_i  in  32  store data.
- flush_i  in  1  invalidate all lines.
- rdata_o  out  32  load data; valid while Ready_cache2cpu_o=1.
- Ready_cache2cpu_o  out  1  one-cycle completion pulse.
- stall_o  out  1  pipeline hold, = Valid_cpu2cache_i & ~Ready_cache2cpu_o (combinational).
- mem_valid_o  out  1  backing-memory request.
- mem_we_o  out  1  1=write.
- mem_addr_o  out  32  word-aligned address, bits [1:0]=0.
- mem_wdata_o  out  32  write data.
- mem_ready_i  in  1  memory accepts a write, or returns read data, this cycle.
- mem_rdata_i  in  32  read data; valid with mem_ready_i.

Behaviour:
- Address split: index = addr[2+IDX_W-1:2], tag = addr[31:2+IDX_W]. Per line: valid bit, tag, 32-bit data.
- Reset (asynchronous, any state):
  - State goes to IDLE; all valid bits cleared.
  - rdata_o, Ready_cache2cpu_o, mem_valid_o, mem_we_o, mem_addr_o and mem_wdata_o are 0.
  - Any in-flight memory transaction is abandoned; mem_valid_o drops immediately.
- State machine (registered state) IDLE, LOOKUP, MISS_RD, WR_THRU, RESP:
  - IDLE:
    - flush_i=1: clear all valid bits this edge and stay in IDLE. Flush has priority over a same-cycle request; that request is captured the following cycle.
    - Otherwise, if Valid_cpu2cache_i=1: latch addr, wdata and MemRW into request registers; go to LOOKUP.
  - LOOKUP: hit = valid[idx] & (tag[idx]==req_tag).
    - Load hit: rdata_o <= line data; go to RESP.
    - Load miss: go to MISS_RD.
    - Store (hit or miss): go to WR_THRU.
  - MISS_RD:
    - Drive mem_valid_o=1, mem_we_o=0, mem_addr_o={req_addr[31:2],2'b00}, all stable until mem_ready_i=1.
    - On the mem_ready_i edge: line[idx] <= {valid=1, req_tag, mem_rdata_i}; rdata_o <= mem_rdata_i; go to RESP.
  - WR_THRU:
    - Drive mem_valid_o=1, mem_we_o=1, address as in MISS_RD, mem_wdata_o=req_wdata, all stable until mem_ready_i=1.
    - On the mem_ready_i edge: if the line hit in LOOKUP, line data <= req_wdata. A miss leaves the line unchanged (no allocate).
    - rdata_o <= 0; go to RESP.
  - RESP: Ready_cache2cpu_o=1 for exactly this cycle; mem_valid_o=0; go to IDLE.
- flush_i outside IDLE is ignored. It is not queued.
- mem_valid_o deasserts the cycle after mem_ready_i is sampled high; there are no back-to-back memory requests.
- Latency, counting the cycle Valid_cpu2cache_i is first sampled in IDLE as cycle 0:
  - Load hit: Ready_cache2cpu_o in cycle 2.
  - Load miss or store: Ready_cache2cpu_o in cycle 3+N, where N is the number of cycles mem_ready_i stays low after mem_valid_o rises.
- The CPU pipeline advances on the RESP edge. A new request can be captured one cycle after RESP, so the minimum request spacing is 3 cycles.
- Request fields that change between capture and RESP are ignored.
- Load miss and store to the same index in successive requests: the second request observes the line state left by the first (fill or hit-update is complete before RESP).
- Index wrap: addresses differing only in tag map to the same line. A fill replaces the previous tag.

Test Plan:
- Reset, then load 0x0000_0040, memory returns 0xDEADBEEF after 2 wait cycles -> mem_valid_o high 3 cycles with mem_addr_o=0x40 and mem_we_o=0; Ready_cache2cpu_o in cycle 5 with rdata_o=0xDEADBEEF. Repeat load -> hit: Ready in cycle 2, no mem_valid_o.
- Store 0x1234_5678 to 0x40 (cached), mem_ready_i immediate -> one write beat with mem_we_o=1 and mem_wdata_o=0x12345678, Ready in cycle 3. Following load 0x40 hits and returns 0x12345678.
- Store to uncached 0x80 -> memory write issued; following load 0x80 misses (no allocate).
- LINES=16: load 0x40, then load 0x80 (same index 0, different tag) -> second access misses and refills. Load 0x40 again -> miss.
- flush_i and Valid_cpu2cache_i both high in IDLE -> flush first; request captured next cycle; previously cached 0x40 now misses.
- Assert rst_i during MISS_RD with mem_valid_o high -> mem_valid_o and stall_o-related Ready drop immediately; after release, load 0x40 misses (valid bits cleared).
